// File: rtl/otter_lsu_split_if.sv
// rtl/otter_lsu_split_if.sv - CPU request/response and memory port 2 bundle for otter_lsu_split
interface otter_lsu_split_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [31:0] REQ_ADDR;
  logic        REQ_WRITE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_SIGN;
  logic [31:0] REQ_WDATA;

  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic        MEM_WRITE2;
  logic        MEM_READ2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;

  // The load/store unit side: takes CPU requests, drives memory port 2
  modport master (
    input  REQ_VALID, REQ_ADDR, REQ_WRITE, REQ_SIZE, REQ_SIGN, REQ_WDATA,
    input  MEM_DOUT2,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
  );

  // The environment side: CPU stage plus memory
  modport slave (
    output REQ_VALID, REQ_ADDR, REQ_WRITE, REQ_SIZE, REQ_SIGN, REQ_WDATA,
    output MEM_DOUT2,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
  );
endinterface

// File: rtl/otter_lsu_split.sv
// rtl/otter_lsu_split.sv - OTTER data-port LSU splitting word-crossing accesses; LSU_MISALIGN_TRAP_EN faults them instead
module otter_lsu_split #(
  parameter logic [31:0] IO_BASE = 32'h11000000
) (
  input logic               CLK,
  input logic               RST_N,
  otter_lsu_split_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESP     = 2'd1,
    LD_LO    = 2'd2,
    ST_BYTES = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   write_q, write_d;
  logic   err_q, err_d;
  logic   req_is_mis;

`ifndef LSU_MISALIGN_TRAP_EN
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] lo_q, lo_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        split_q, split_d;
  logic [1:0]  byte_idx;
  logic [7:0]  st_byte;
  logic [31:0] merge_word;
  logic [31:0] merged;
`endif

  // A request crosses a word boundary only below the MMIO window; MMIO is never split
  assign req_is_mis = (bus.REQ_ADDR < IO_BASE) &&
                      (((bus.REQ_SIZE == 2'd1) && (bus.REQ_ADDR[1:0] == 2'd3)) ||
                       ((bus.REQ_SIZE == 2'd2) && (bus.REQ_ADDR[1:0] != 2'd0)));

`ifndef LSU_MISALIGN_TRAP_EN
  // Split datapath: current store byte and the merged/extended load word
  always_comb begin
    // cnt_q counts remaining bytes, so for a word the byte index is 4-cnt (mod 4)
    byte_idx   = (size_q == 2'd2) ? (2'd0 - cnt_q) : 2'd1;
    st_byte    = wdata_q[{byte_idx, 3'b000} +: 8];
    merge_word = 32'({bus.MEM_DOUT2, lo_q} >> {addr_q[1:0], 3'b000});
    if (size_q == 2'd2) begin
      merged = merge_word;
    end else begin
      merged = {{16{merge_word[15] & ~sign_q}}, merge_word[15:0]};
    end
  end
`endif

  // Next state, memory port drive and response generation
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    err_d   = err_q;
`ifndef LSU_MISALIGN_TRAP_EN
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    split_d = split_q;
`endif
    bus.REQ_READY  = 1'b0;
    bus.RSP_VALID  = 1'b0;
    bus.RSP_RDATA  = 32'h0;
    bus.RSP_ERR    = 1'b0;
    bus.MEM_ADDR2  = 32'h0;
    bus.MEM_DIN2   = 32'h0;
    bus.MEM_WRITE2 = 1'b0;
    bus.MEM_READ2  = 1'b0;
    bus.MEM_SIZE   = 2'd0;
    bus.MEM_SIGN   = 1'b0;

    case (state_q)
      IDLE: begin
        bus.REQ_READY = 1'b1;
        if (bus.REQ_VALID) begin
          write_d = bus.REQ_WRITE;
          err_d   = (bus.REQ_SIZE == 2'd3);
          state_d = RESP;
`ifndef LSU_MISALIGN_TRAP_EN
          addr_d  = bus.REQ_ADDR;
          wdata_d = bus.REQ_WDATA;
          size_d  = bus.REQ_SIZE;
          sign_d  = bus.REQ_SIGN;
          split_d = 1'b0;
`endif
          if (req_is_mis) begin
`ifdef LSU_MISALIGN_TRAP_EN
            err_d = 1'b1;
`else
            if (bus.REQ_WRITE) begin
              // Byte 0 goes out now; the rest follow one per cycle
              bus.MEM_ADDR2  = bus.REQ_ADDR;
              bus.MEM_SIZE   = 2'd0;
              bus.MEM_DIN2   = {24'h0, bus.REQ_WDATA[7:0]};
              bus.MEM_WRITE2 = 1'b1;
              cnt_d          = (bus.REQ_SIZE == 2'd2) ? 2'd3 : 2'd1;
              state_d        = ST_BYTES;
            end else begin
              bus.MEM_ADDR2 = {bus.REQ_ADDR[31:2], 2'b00};
              bus.MEM_SIZE  = 2'd2;
              bus.MEM_READ2 = 1'b1;
              split_d       = 1'b1;
              state_d       = LD_LO;
            end
`endif
          end else begin
            bus.MEM_ADDR2 = bus.REQ_ADDR;
            bus.MEM_SIZE  = bus.REQ_SIZE;
            bus.MEM_SIGN  = bus.REQ_SIGN;
            bus.MEM_DIN2  = bus.REQ_WDATA;
            // Illegal size carries its fields but never strobes memory
            if (bus.REQ_SIZE != 2'd3) begin
              bus.MEM_WRITE2 = bus.REQ_WRITE;
              bus.MEM_READ2  = ~bus.REQ_WRITE;
            end
          end
        end
      end

      RESP: begin
        bus.RSP_VALID = 1'b1;
        bus.RSP_ERR   = err_q;
        if (!err_q && !write_q) begin
`ifdef LSU_MISALIGN_TRAP_EN
          bus.RSP_RDATA = bus.MEM_DOUT2;
`else
          bus.RSP_RDATA = split_q ? merged : bus.MEM_DOUT2;
`endif
        end
        state_d = IDLE;
      end

`ifndef LSU_MISALIGN_TRAP_EN
      LD_LO: begin
        // Low word arrives now; fetch the next word, wrapping at the top of memory
        lo_d          = bus.MEM_DOUT2;
        bus.MEM_ADDR2 = {addr_q[31:2], 2'b00} + 32'd4;
        bus.MEM_SIZE  = 2'd2;
        bus.MEM_READ2 = 1'b1;
        state_d       = RESP;
      end

      ST_BYTES: begin
        bus.MEM_ADDR2  = addr_q + {30'h0, byte_idx};
        bus.MEM_SIZE   = 2'd0;
        bus.MEM_DIN2   = {24'h0, st_byte};
        bus.MEM_WRITE2 = 1'b1;
        cnt_d          = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = RESP;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      err_q   <= 1'b0;
`ifndef LSU_MISALIGN_TRAP_EN
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
      size_q  <= 2'd0;
      cnt_q   <= 2'd0;
      sign_q  <= 1'b0;
      split_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      err_q   <= err_d;
`ifndef LSU_MISALIGN_TRAP_EN
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      split_q <= split_d;
`endif
    end
  end

endmodule

// File: tb/tb_otter_lsu_split.sv
// tb/tb_otter_lsu_split.sv - scoreboard bench for otter_lsu_split with byte memory model
module tb_otter_lsu_split;
  localparam logic [31:0] IO_BASE = 32'h11000000;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  otter_lsu_split_if bus ();

  otter_lsu_split #(.IO_BASE(IO_BASE)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          c;
  } exp_t;

  typedef struct {
    int          c;
    logic        wr;
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] d;
  } acc_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_t = 0;
  int rsp_cnt = 0;
  exp_t sb_q[$];
  acc_t log_q[$];
  exp_t mon_e;

  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [31:0] mem_dout = 32'h0;

  assign bus.MEM_DOUT2 = mem_dout;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd2) ? 4 : ((s == 2'd1) ? 2 : 1);
  endfunction

  // Byte-wise read with OTTER-style extension (uns=1 means zero-extend)
  function automatic logic [31:0] fetch(input bit from_ref, input logic [31:0] a,
                                        input logic [1:0] s, input logic uns);
    logic [31:0] v;
    logic [31:0] ak;
    int n;
    v = 32'h0;
    if (a >= IO_BASE) return 32'hC0DE0000 | {16'h0, a[15:0]};
    n = nbytes(s);
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      v[8*k +: 8] = from_ref ? ref_mem[ak[11:0]] : mem[ak[11:0]];
    end
    if (!uns && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!uns && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Memory port 2 model: read data one cycle after the strobe
  always @(posedge CLK) begin
    if (bus.MEM_READ2) mem_dout <= fetch(1'b0, bus.MEM_ADDR2, bus.MEM_SIZE, bus.MEM_SIGN);
    if (bus.MEM_WRITE2 && bus.MEM_ADDR2 < IO_BASE) begin
      for (int k = 0; k < nbytes(bus.MEM_SIZE); k++) begin
        mem[12'(bus.MEM_ADDR2 + 32'(k))] <= bus.MEM_DIN2[8*k +: 8];
      end
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: strobe exclusivity, access log, response scoreboard
  always @(negedge CLK) begin
    check("rw_exclusive", {31'h0, bus.MEM_READ2 & bus.MEM_WRITE2}, 32'h0);
    if (bus.MEM_READ2 || bus.MEM_WRITE2)
      log_q.push_back('{cyc, bus.MEM_WRITE2, bus.MEM_ADDR2, bus.MEM_SIZE, bus.MEM_DIN2});
    if (bus.RSP_VALID) begin
      rsp_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 32'h1, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_rdata", bus.RSP_RDATA, mon_e.rd);
        check("rsp_err", {31'h0, bus.RSP_ERR}, {31'h0, mon_e.err});
        check("rsp_cycle", 32'(cyc), 32'(mon_e.c));
      end
    end
  end

  // Reference behaviour; keeps ref_mem in step with completed stores
  task automatic model(input logic [31:0] a, input logic w, input logic [1:0] s, input logic sg,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err,
                       output int lat);
    bit mis;
    int n;
    logic [31:0] ak;
    mis = (a < IO_BASE) && (((s == 2'd1) && (a[1:0] == 2'd3)) || ((s == 2'd2) && (a[1:0] != 2'd0)));
    n = nbytes(s);
    rd = 32'h0;
    err = 1'b0;
    lat = 1;
    if (s == 2'd3) begin
      err = 1'b1;
    end else if (mis) begin
`ifdef LSU_MISALIGN_TRAP_EN
      err = 1'b1;
`else
      lat = w ? n : 2;
      if (w) begin
        for (int k = 0; k < n; k++) begin
          ak = a + 32'(k);
          ref_mem[ak[11:0]] = wd[8*k +: 8];
        end
      end else begin
        rd = fetch(1'b1, a, s, sg);
      end
`endif
    end else if (w) begin
      if (a < IO_BASE) begin
        for (int k = 0; k < n; k++) begin
          ak = a + 32'(k);
          ref_mem[ak[11:0]] = wd[8*k +: 8];
        end
      end
    end else begin
      rd = fetch(1'b1, a, s, sg);
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic w, input logic [1:0] s, input logic sg,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee, input int lat);
    bit got;
    got = 1'b0;
    log_q.delete();
    @(posedge CLK);
    #1;
    bus.REQ_ADDR  = a;
    bus.REQ_WRITE = w;
    bus.REQ_SIZE  = s;
    bus.REQ_SIGN  = sg;
    bus.REQ_WDATA = wd;
    bus.REQ_VALID = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.REQ_READY) begin
        got = 1'b1;
        last_t = cyc;
        sb_q.push_back('{er, ee, cyc + lat});
        @(posedge CLK);
        #1;
        bus.REQ_VALID = 1'b0;
        bus.REQ_ADDR  = $urandom;
        bus.REQ_WRITE = 1'($urandom);
        bus.REQ_SIZE  = 2'($urandom);
        bus.REQ_SIGN  = 1'($urandom);
        bus.REQ_WDATA = $urandom;
      end else begin
        @(posedge CLK);
        #1;
      end
    end
    if (!got) begin
      check("accept_timeout", 32'h0, 32'h1);
      bus.REQ_VALID = 1'b0;
    end
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) begin
      @(negedge CLK);
      #1;
    end
    check("rsp_drain", 32'(sb_q.size()), 32'h0);
    sb_q.delete();
  endtask

  task automatic directed(input logic [31:0] a, input logic w, input logic [1:0] s, input logic sg,
                          input logic [31:0] wd, input logic [31:0] er, input logic ee, input int lat);
    logic [31:0] rd_m;
    logic err_m;
    int lat_m;
    model(a, w, s, sg, wd, rd_m, err_m, lat_m);
    do_req(a, w, s, sg, wd, er, ee, lat);
  endtask

  task automatic run_rand(input logic [31:0] a, input logic w, input logic [1:0] s, input logic sg,
                          input logic [31:0] wd);
    logic [31:0] rd_m;
    logic err_m;
    int lat_m;
    model(a, w, s, sg, wd, rd_m, err_m, lat_m);
    do_req(a, w, s, sg, wd, rd_m, err_m, lat_m);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'h0, bus.REQ_READY}, 32'h1);
    check({tag, "_rsp_valid"}, {31'h0, bus.RSP_VALID}, 32'h0);
    check({tag, "_rsp_rdata"}, bus.RSP_RDATA, 32'h0);
    check({tag, "_rsp_err"}, {31'h0, bus.RSP_ERR}, 32'h0);
    check({tag, "_mem_addr"}, bus.MEM_ADDR2, 32'h0);
    check({tag, "_mem_din"}, bus.MEM_DIN2, 32'h0);
    check({tag, "_mem_wr"}, {31'h0, bus.MEM_WRITE2}, 32'h0);
    check({tag, "_mem_rd"}, {31'h0, bus.MEM_READ2}, 32'h0);
    check({tag, "_mem_size"}, {30'h0, bus.MEM_SIZE}, 32'h0);
    check({tag, "_mem_sign"}, {31'h0, bus.MEM_SIGN}, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    logic [7:0] b;
    logic [31:0] a;
    logic [1:0] s;
    int base;
    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]} = 32'h44332211;
    {mem[12'h107], mem[12'h106], mem[12'h105], mem[12'h104]} = 32'h887766F5;
    {ref_mem[12'h103], ref_mem[12'h102], ref_mem[12'h101], ref_mem[12'h100]} = 32'h44332211;
    {ref_mem[12'h107], ref_mem[12'h106], ref_mem[12'h105], ref_mem[12'h104]} = 32'h887766F5;

    bus.REQ_VALID = 1'b0;
    bus.REQ_ADDR  = 32'h0;
    bus.REQ_WRITE = 1'b0;
    bus.REQ_SIZE  = 2'd0;
    bus.REQ_SIGN  = 1'b0;
    bus.REQ_WDATA = 32'h0;

    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    directed(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 32'h44332211, 1'b0, 1);
    check("lw_al_nacc", 32'(log_q.size()), 32'h1);
    check("lw_al_addr", log_q[0].a, 32'h100);
    check("lw_al_cyc", 32'(log_q[0].c), 32'(last_t));
    check("lw_al_rd", {31'h0, log_q[0].wr}, 32'h0);

`ifndef LSU_MISALIGN_TRAP_EN
    directed(32'h102, 1'b0, 2'd2, 1'b0, 32'h0, 32'h66F54433, 1'b0, 2);
    check("lw_mis_nacc", 32'(log_q.size()), 32'h2);
    check("lw_mis_a0", log_q[0].a, 32'h100);
    check("lw_mis_c0", 32'(log_q[0].c), 32'(last_t));
    check("lw_mis_a1", log_q[1].a, 32'h104);
    check("lw_mis_c1", 32'(log_q[1].c), 32'(last_t + 1));

    directed(32'h103, 1'b0, 2'd1, 1'b0, 32'h0, 32'hFFFFF544, 1'b0, 2);
    directed(32'h103, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0000F544, 1'b0, 2);

    directed(32'h201, 1'b1, 2'd2, 1'b0, 32'hA1B2C3D4, 32'h0, 1'b0, 4);
    check("sw_mis_nacc", 32'(log_q.size()), 32'h4);
    for (int k = 0; k < 4; k++) begin
      check("sw_mis_addr", log_q[k].a, 32'h201 + 32'(k));
      check("sw_mis_byte", {24'h0, log_q[k].d[7:0]}, {24'h0, 8'(32'hA1B2C3D4 >> (8 * k))});
      check("sw_mis_cyc", 32'(log_q[k].c), 32'(last_t + k));
      check("sw_mis_size", {30'h0, log_q[k].s}, 32'h0);
      check("sw_mis_wr", {31'h0, log_q[k].wr}, 32'h1);
    end
    directed(32'h201, 1'b0, 2'd2, 1'b0, 32'h0, 32'hA1B2C3D4, 1'b0, 2);
`else
    directed(32'h102, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    check("trap_lw_nacc", 32'(log_q.size()), 32'h0);
    directed(32'h201, 1'b1, 2'd2, 1'b0, 32'hA1B2C3D4, 32'h0, 1'b1, 1);
    check("trap_sw_nacc", 32'(log_q.size()), 32'h0);
`endif

    directed(32'h11000002, 1'b0, 2'd2, 1'b0, 32'h0, 32'hC0DE0002, 1'b0, 1);
    check("mmio_nacc", 32'(log_q.size()), 32'h1);
    check("mmio_addr", log_q[0].a, 32'h11000002);
    check("mmio_size", {30'h0, log_q[0].s}, 32'h2);

    directed(32'h300, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    check("illegal_nacc", 32'(log_q.size()), 32'h0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) a = IO_BASE + 32'($urandom_range(0, 255));
      else a = 32'($urandom_range(0, 4080));
      if ($urandom_range(0, 9) == 0) s = 2'd3;
      else s = 2'($urandom_range(0, 2));
      run_rand(a, 1'($urandom), s, 1'($urandom), $urandom);
    end

`ifndef LSU_MISALIGN_TRAP_EN
    @(posedge CLK);
    #1;
    bus.REQ_ADDR  = 32'h102;
    bus.REQ_WRITE = 1'b0;
    bus.REQ_SIZE  = 2'd2;
    bus.REQ_SIGN  = 1'b0;
    bus.REQ_VALID = 1'b1;
    check("rst_pre_ready", {31'h0, bus.REQ_READY}, 32'h1);
    @(posedge CLK);
    #1;
    bus.REQ_VALID = 1'b0;
    check("rst_ldlo_rd", {31'h0, bus.MEM_READ2}, 32'h1);
    check("rst_ldlo_addr", bus.MEM_ADDR2, 32'h104);
    base = rsp_cnt;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (6) @(negedge CLK);
    check("rst_no_rsp", 32'(rsp_cnt - base), 32'h0);
    check("rst_post_ready", {31'h0, bus.REQ_READY}, 32'h1);
    directed(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 32'h44332211, 1'b0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
